// File: rtl/fpu_mul_pipe_if.sv
// rtl/fpu_mul_pipe_if.sv - operand/result handshake bundle for fpu_mul_pipe
interface fpu_mul_pipe_if #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23,
   parameter int TAG_W = 6
);
   localparam int W = 1 + EXP_W + MAN_W;

   logic             in_valid;
   logic             in_ready;
   logic [W-1:0]     in_a;
   logic [W-1:0]     in_b;
   logic [2:0]       in_rmode;
   logic [TAG_W-1:0] in_tag;
   logic             out_valid;
   logic             out_ready;
   logic [W-1:0]     out_res;
   logic [TAG_W-1:0] out_tag;
   logic [4:0]       out_flags;

   modport master (
      output in_valid, in_a, in_b, in_rmode, in_tag, out_ready,
      input  in_ready, out_valid, out_res, out_tag, out_flags
   );

   modport slave (
      input  in_valid, in_a, in_b, in_rmode, in_tag, out_ready,
      output in_ready, out_valid, out_res, out_tag, out_flags
   );
endinterface

// File: rtl/fpu_mul_pipe.sv
// rtl/fpu_mul_pipe.sv - three-stage pipelined floating-point multiplier, flush-to-zero
// Stages: unpack/classify, mantissa multiply, normalise/round/pack. Whole pipe freezes on stall.
module fpu_mul_pipe #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23,
   parameter int TAG_W = 6
) (
   input logic           clk,
   input logic           rst,
   fpu_mul_pipe_if.slave bus
);
   localparam int W   = 1 + EXP_W + MAN_W;
   localparam int EW2 = EXP_W + 2;
   localparam int PW  = 2 * MAN_W + 2;
   localparam logic [EW2-1:0] BIAS    = {3'b000, {(EXP_W-1){1'b1}}};
   localparam logic [EW2-1:0] EXP_MAX = {2'b00, {EXP_W{1'b1}}};
   localparam logic [W-1:0]   QNAN    = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

   logic advance;
   assign advance      = ~(bus.out_valid & ~bus.out_ready);
   assign bus.in_ready = advance;

   logic             sa, sb, sign_ab;
   logic [EXP_W-1:0] ea, eb;
   logic [MAN_W-1:0] fa, fb;
   logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_snan, b_snan, a_den, b_den;

   assign {sa, ea, fa} = bus.in_a;
   assign {sb, eb, fb} = bus.in_b;
   assign sign_ab = sa ^ sb;
   // a zero exponent counts as zero whether or not the fraction is set
   assign a_zero  = (ea == '0);
   assign b_zero  = (eb == '0);
   assign a_den   = a_zero & (|fa);
   assign b_den   = b_zero & (|fb);
   assign a_nan   = (&ea) & (|fa);
   assign b_nan   = (&eb) & (|fb);
   assign a_inf   = (&ea) & ~(|fa);
   assign b_inf   = (&eb) & ~(|fb);
   assign a_snan  = a_nan & ~fa[MAN_W-1];
   assign b_snan  = b_nan & ~fb[MAN_W-1];

   logic         c_special, c_invalid;
   logic [W-1:0] c_spec_res;

   always_comb begin
      c_special  = 1'b1;
      c_invalid  = 1'b0;
      c_spec_res = '0;
      if (a_nan | b_nan) begin
         c_spec_res = QNAN;
         c_invalid  = a_snan | b_snan;
      end else if ((a_inf & b_zero) | (b_inf & a_zero)) begin
         c_spec_res = QNAN;
         c_invalid  = 1'b1;
      end else if (a_inf | b_inf) begin
         c_spec_res = {sign_ab, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      end else if (a_zero | b_zero) begin
         c_spec_res = {sign_ab, {(W-1){1'b0}}};
      end else begin
         c_special = 1'b0;
      end
   end

   logic             s1_valid, s1_sign, s1_special, s1_den, s1_inv;
   logic [EW2-1:0]   s1_exp;
   logic [MAN_W:0]   s1_ma, s1_mb;
   logic [W-1:0]     s1_spec_res;
   logic [2:0]       s1_rmode;
   logic [TAG_W-1:0] s1_tag;

   logic             s2_valid, s2_sign, s2_special, s2_den, s2_inv;
   logic [EW2-1:0]   s2_exp;
   logic [PW-1:0]    s2_prod;
   logic [W-1:0]     s2_spec_res;
   logic [2:0]       s2_rmode;
   logic [TAG_W-1:0] s2_tag;

   logic [W-1:0]     r_res;
   logic [4:0]       r_flags;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_valid      <= 1'b0;
         s1_sign       <= 1'b0;
         s1_special    <= 1'b0;
         s1_den        <= 1'b0;
         s1_inv        <= 1'b0;
         s1_exp        <= '0;
         s1_ma         <= '0;
         s1_mb         <= '0;
         s1_spec_res   <= '0;
         s1_rmode      <= '0;
         s1_tag        <= '0;
         s2_valid      <= 1'b0;
         s2_sign       <= 1'b0;
         s2_special    <= 1'b0;
         s2_den        <= 1'b0;
         s2_inv        <= 1'b0;
         s2_exp        <= '0;
         s2_prod       <= '0;
         s2_spec_res   <= '0;
         s2_rmode      <= '0;
         s2_tag        <= '0;
         bus.out_valid <= 1'b0;
         bus.out_res   <= '0;
         bus.out_tag   <= '0;
         bus.out_flags <= '0;
      end else if (advance) begin
         s1_valid      <= bus.in_valid;
         s1_sign       <= sign_ab;
         s1_special    <= c_special;
         s1_den        <= a_den | b_den;
         s1_inv        <= c_invalid;
         s1_exp        <= {2'b00, ea} + {2'b00, eb} - BIAS;
         s1_ma         <= {1'b1, fa};
         s1_mb         <= {1'b1, fb};
         s1_spec_res   <= c_spec_res;
         s1_rmode      <= bus.in_rmode;
         s1_tag        <= bus.in_tag;
         s2_valid      <= s1_valid;
         s2_sign       <= s1_sign;
         s2_special    <= s1_special;
         s2_den        <= s1_den;
         s2_inv        <= s1_inv;
         s2_exp        <= s1_exp;
         s2_prod       <= s1_ma * s1_mb;
         s2_spec_res   <= s1_spec_res;
         s2_rmode      <= s1_rmode;
         s2_tag        <= s1_tag;
         bus.out_valid <= s2_valid;
         bus.out_res   <= s2_valid ? r_res   : '0;
         bus.out_tag   <= s2_valid ? s2_tag  : '0;
         bus.out_flags <= s2_valid ? r_flags : '0;
      end
   end

   logic [PW-1:0]    norm;
   logic [MAN_W:0]   mant;
   logic [MAN_W-1:0] frac;
   logic [EW2-1:0]   e1, e2;
   logic             guard, sticky, inc, carry, ovf_inf;

   always_comb begin
      norm    = s2_prod[PW-1] ? s2_prod : {s2_prod[PW-2:0], 1'b0};
      mant    = norm[PW-1:MAN_W+1];
      guard   = norm[MAN_W];
      sticky  = |norm[MAN_W-1:0];
      e1      = s2_exp + {{(EW2-1){1'b0}}, s2_prod[PW-1]};
      inc     = 1'b0;
      ovf_inf = 1'b1;
      case (s2_rmode)
         3'd0: begin inc = 1'b0;                        ovf_inf = 1'b0;     end
         3'd1: begin inc = guard;                       ovf_inf = 1'b1;     end
         3'd3: begin inc = ~s2_sign & (guard | sticky); ovf_inf = ~s2_sign; end
         3'd4: begin inc = s2_sign & (guard | sticky);  ovf_inf = s2_sign;  end
         default: begin inc = guard & (sticky | mant[0]); ovf_inf = 1'b1;   end
      endcase
      // all-ones mantissa plus one wraps the fraction to zero and bumps the exponent
      carry   = inc & (&mant);
      frac    = mant[MAN_W-1:0] + {{(MAN_W-1){1'b0}}, inc};
      e2      = e1 + {{(EW2-1){1'b0}}, carry};
      r_res   = {s2_sign, e2[EXP_W-1:0], frac};
      r_flags = {guard | sticky, 4'b0000};
      if (s2_special) begin
         r_res   = s2_spec_res;
         r_flags = {3'b000, s2_den, s2_inv};
      end else if (e1[EW2-1] | (e1 == '0)) begin
         r_res   = {s2_sign, {(W-1){1'b0}}};
         r_flags = 5'b11000;
      end else if (e2 >= EXP_MAX) begin
         r_res   = ovf_inf ? {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}}
                           : {s2_sign, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
         r_flags = 5'b10100;
      end
   end
endmodule

// File: tb/tb_fpu_mul_pipe.sv
// tb/tb_fpu_mul_pipe.sv - self-checking bench for fpu_mul_pipe (binary32 configuration)
module tb_fpu_mul_pipe;
   logic clk;
   logic rst;
   int   checks   = 0;
   int   failures = 0;
   int   n_sent   = 0;
   int   n_recv   = 0;
   int   n_stall  = 0;
   bit   mon_en   = 0;
   bit   stream_done;

   fpu_mul_pipe_if #(.EXP_W(8), .MAN_W(23), .TAG_W(6)) bus ();

   fpu_mul_pipe #(.EXP_W(8), .MAN_W(23), .TAG_W(6)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [2:0]  rm;
      logic [5:0]  tag;
      logic [31:0] res;
      logic [4:0]  flags;
   } vec_t;

   typedef struct packed {
      logic [31:0] res;
      logic [5:0]  tag;
      logic [4:0]  flags;
   } exp_t;

   localparam int NV = 21;
   vec_t vecs [NV];
   exp_t exp_q [$];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, want);
      end
   endtask

   // Reference: exact integer product, rounded by comparing the discarded remainder with half an ulp.
   function automatic logic [36:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input logic [2:0] rm);
      logic sign, a_nan, b_nan, a_snan, b_snan, a_inf, b_inf, a_zero, b_zero, den, up, inexact, to_inf;
      int ea, eb, e, sh, m;
      longint unsigned ma, mb, prod, q, rem, half;
      sign   = a[31] ^ b[31];
      ea     = {24'd0, a[30:23]};
      eb     = {24'd0, b[30:23]};
      a_nan  = (ea == 255) && (a[22:0] != 0);
      b_nan  = (eb == 255) && (b[22:0] != 0);
      a_snan = a_nan && !a[22];
      b_snan = b_nan && !b[22];
      a_inf  = (ea == 255) && (a[22:0] == 0);
      b_inf  = (eb == 255) && (b[22:0] == 0);
      a_zero = (ea == 0);
      b_zero = (eb == 0);
      den    = (a_zero && a[22:0] != 0) || (b_zero && b[22:0] != 0);
      m      = (rm > 3'd4) ? 2 : {29'd0, rm};
      if (a_nan || b_nan) return {32'h7FC00000, 3'b000, den, a_snan | b_snan};
      if ((a_inf && b_zero) || (b_inf && a_zero)) return {32'h7FC00000, 3'b000, den, 1'b1};
      if (a_inf || b_inf) return {sign, 8'hFF, 23'd0, 3'b000, den, 1'b0};
      if (a_zero || b_zero) return {sign, 31'd0, 3'b000, den, 1'b0};
      ma   = {40'd0, 1'b1, a[22:0]};
      mb   = {40'd0, 1'b1, b[22:0]};
      prod = ma * mb;
      e    = ea + eb - 127;
      if (prod >= 64'h0000_8000_0000_0000) begin
         sh = 24;
         e  = e + 1;
      end else begin
         sh = 23;
      end
      if (e <= 0) return {sign, 31'd0, 5'b11000};
      q       = prod >> sh;
      rem     = prod - (q << sh);
      half    = 64'd1 << (sh - 1);
      inexact = (rem != 0);
      case (m)
         0:       up = 1'b0;
         1:       up = (rem >= half);
         3:       up = !sign && inexact;
         4:       up = sign && inexact;
         default: up = (rem > half) || ((rem == half) && q[0]);
      endcase
      q = q + {63'd0, up};
      if (q == (64'd1 << 24)) begin
         q = 64'd1 << 23;
         e = e + 1;
      end
      if (e >= 255) begin
         to_inf = (m == 1) || (m == 2) || (m == 3 && !sign) || (m == 4 && sign);
         return to_inf ? {sign, 8'hFF, 23'd0, 5'b10100} : {sign, 8'hFE, 23'h7FFFFF, 5'b10100};
      end
      return {sign, e[7:0], q[22:0], inexact, 4'b0000};
   endfunction

   function automatic logic [31:0] rand_op();
      logic [31:0] v;
      int sel;
      v   = $urandom;
      sel = $urandom_range(0, 9);
      if (sel < 6)       v[30:23] = 8'($urandom_range(100, 154));
      else if (sel == 6) v[30:23] = 8'hFF;
      else if (sel == 7) v[30:23] = 8'h00;
      else if (sel == 8) v[30:23] = 8'($urandom_range(200, 254));
      return v;
   endfunction

   // Single operation on an otherwise idle pipe; checks latency and every output field.
   task automatic run_one(input vec_t v);
      int cyc;
      bus.in_a     = v.a;
      bus.in_b     = v.b;
      bus.in_rmode = v.rm;
      bus.in_tag   = v.tag;
      bus.in_valid = 1'b1;
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.in_valid = 1'b0;
      cyc = 1;
      #1;
      while (!bus.out_valid && cyc < 20) begin
         @(negedge clk);
         #1;
         cyc++;
      end
      check($sformatf("latency tag=%0h", v.tag), 32'(cyc), 32'd3);
      check($sformatf("res tag=%0h", v.tag), bus.out_res, v.res);
      check($sformatf("tag tag=%0h", v.tag), 32'(bus.out_tag), 32'(v.tag));
      check($sformatf("flags tag=%0h", v.tag), 32'(bus.out_flags), 32'(v.flags));
      @(negedge clk);
   endtask

   // Streaming driver: entered on a negedge, holds the op until accepted, records the expectation.
   task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [2:0] rm, input logic [5:0] tag);
      int waited;
      logic [36:0] r;
      bus.in_a     = a;
      bus.in_b     = b;
      bus.in_rmode = rm;
      bus.in_tag   = tag;
      bus.in_valid = 1'b1;
      waited = 0;
      #1;
      while (!bus.in_ready && waited < 200) begin
         @(negedge clk);
         #1;
         waited++;
      end
      if (!bus.in_ready) begin
         check("accept_timeout", 32'(bus.in_ready), 32'd1);
      end else begin
         r = ref_mul(a, b, rm);
         exp_q.push_back({r[36:5], tag, r[4:0]});
         n_sent++;
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
   endtask

   logic        was_stalled = 0;
   logic [31:0] held_res;
   logic [5:0]  held_tag;
   logic [4:0]  held_flags;

   always @(negedge clk) begin
      #1;
      if (mon_en && rst) begin
         if (bus.out_valid && !bus.out_ready) begin
            n_stall++;
            check("stall_in_ready", 32'(bus.in_ready), 32'd0);
            if (was_stalled) begin
               check("stall_hold_res", bus.out_res, held_res);
               check("stall_hold_tag", 32'(bus.out_tag), 32'(held_tag));
               check("stall_hold_flags", 32'(bus.out_flags), 32'(held_flags));
            end
            was_stalled = 1'b1;
            held_res    = bus.out_res;
            held_tag    = bus.out_tag;
            held_flags  = bus.out_flags;
         end else begin
            was_stalled = 1'b0;
         end
         if (bus.out_valid && bus.out_ready) begin
            n_recv++;
            if (exp_q.size() == 0) begin
               check("unexpected_result_tag", 32'(bus.out_tag), 32'hFFFF_FFFF);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               check($sformatf("stream_res tag=%0h", e.tag), bus.out_res, e.res);
               check($sformatf("stream_tag tag=%0h", e.tag), 32'(bus.out_tag), 32'(e.tag));
               check($sformatf("stream_flags tag=%0h", e.tag), 32'(bus.out_flags), 32'(e.flags));
            end
         end
      end else begin
         was_stalled = 1'b0;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      int w;
      bit stale;
      clk = 1'b0;
      rst = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_a      = '0;
      bus.in_b      = '0;
      bus.in_rmode  = '0;
      bus.in_tag    = '0;
      bus.out_ready = 1'b1;

      vecs[0]  = '{32'h3FC00000, 32'h40000000, 3'd2, 6'h15, 32'h40400000, 5'b00000};
      vecs[1]  = '{32'h3F800800, 32'h3F800800, 3'd2, 6'h01, 32'h3F801000, 5'b10000};
      vecs[2]  = '{32'h3F800800, 32'h3F800800, 3'd1, 6'h02, 32'h3F801001, 5'b10000};
      vecs[3]  = '{32'h3F800800, 32'h3F800800, 3'd7, 6'h03, 32'h3F801000, 5'b10000};
      vecs[4]  = '{32'h3F800800, 32'h3F800800, 3'd3, 6'h04, 32'h3F801001, 5'b10000};
      vecs[5]  = '{32'h3F800800, 32'h3F800800, 3'd4, 6'h05, 32'h3F801000, 5'b10000};
      vecs[6]  = '{32'h7F7FFFFF, 32'h40000000, 3'd2, 6'h06, 32'h7F800000, 5'b10100};
      vecs[7]  = '{32'h7F7FFFFF, 32'h40000000, 3'd0, 6'h07, 32'h7F7FFFFF, 5'b10100};
      vecs[8]  = '{32'hFF7FFFFF, 32'h40000000, 3'd3, 6'h08, 32'hFF7FFFFF, 5'b10100};
      vecs[9]  = '{32'hFF7FFFFF, 32'h40000000, 3'd4, 6'h09, 32'hFF800000, 5'b10100};
      vecs[10] = '{32'h7F800000, 32'h00000000, 3'd2, 6'h0A, 32'h7FC00000, 5'b00001};
      vecs[11] = '{32'h7F800001, 32'h3F800000, 3'd2, 6'h0B, 32'h7FC00000, 5'b00001};
      vecs[12] = '{32'h7FC00001, 32'h3F800000, 3'd2, 6'h0C, 32'h7FC00000, 5'b00000};
      vecs[13] = '{32'h00000001, 32'h3F800000, 3'd2, 6'h0D, 32'h00000000, 5'b00010};
      vecs[14] = '{32'h0D800000, 32'h0D800000, 3'd2, 6'h0E, 32'h00000000, 5'b11000};
      vecs[15] = '{32'hFF800000, 32'h40000000, 3'd2, 6'h0F, 32'hFF800000, 5'b00000};
      vecs[16] = '{32'h80000000, 32'h40400000, 3'd2, 6'h10, 32'h80000000, 5'b00000};
      vecs[17] = '{32'h3FFFFFFE, 32'h3F800001, 3'd2, 6'h11, 32'h40000000, 5'b10000};
      vecs[18] = '{32'h3FFFFFFE, 32'h3F800001, 3'd0, 6'h12, 32'h3FFFFFFF, 5'b10000};
      vecs[19] = '{32'h7F7FFFFF, 32'h40000000, 3'd5, 6'h13, 32'h7F800000, 5'b10100};
      vecs[20] = '{32'h00000001, 32'h7F800000, 3'd2, 6'h14, 32'h7FC00000, 5'b00011};

      #3 rst = 1'b0;
      #20;
      check("reset_out_valid", 32'(bus.out_valid), 32'd0);
      check("reset_in_ready", 32'(bus.in_ready), 32'd1);
      check("reset_out_res", bus.out_res, 32'd0);
      check("reset_out_tag", 32'(bus.out_tag), 32'd0);
      check("reset_out_flags", 32'(bus.out_flags), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      for (int i = 0; i < NV; i++) run_one(vecs[i]);

      // Six back-to-back ops with the consumer stalled for cycles 4..9.
      mon_en  = 1'b1;
      base    = n_recv;
      n_stall = 0;
      fork
         begin
            for (int i = 0; i < 6; i++)
               drive(32'h3F800000 + (32'(i) << 20), 32'h40000000 + (32'(i) << 18), 3'd2, 6'(32 + i));
         end
         begin
            for (int c = 0; c < 12; c++) begin
               bus.out_ready = !(c >= 4 && c <= 9);
               @(negedge clk);
            end
            bus.out_ready = 1'b1;
         end
      join
      w = 0;
      while (exp_q.size() != 0 && w < 100) begin
         @(negedge clk);
         w++;
      end
      check("bp_drain", 32'(exp_q.size()), 32'd0);
      check("bp_count", 32'(n_recv - base), 32'd6);
      check("bp_stall_cycles", 32'(n_stall), 32'd6);

      // Asynchronous reset with three operations in flight.
      mon_en = 1'b0;
      repeat (3) @(negedge clk);
      bus.out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         bus.in_a     = rand_op();
         bus.in_b     = rand_op();
         bus.in_rmode = 3'd2;
         bus.in_tag   = 6'(40 + i);
         bus.in_valid = 1'b1;
         @(negedge clk);
      end
      bus.in_valid = 1'b0;
      check("pre_reset_valid", 32'(bus.out_valid), 32'd1);
      #2 rst = 1'b0;
      #1;
      check("async_rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("async_rst_out_res", bus.out_res, 32'd0);
      check("async_rst_out_tag", 32'(bus.out_tag), 32'd0);
      check("async_rst_out_flags", 32'(bus.out_flags), 32'd0);
      check("async_rst_in_ready", 32'(bus.in_ready), 32'd1);
      @(negedge clk);
      rst = 1'b1;
      stale = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         #1;
         if (bus.out_valid) stale = 1'b1;
      end
      check("post_reset_no_stale", 32'(stale), 32'd0);
      @(negedge clk);
      run_one(vecs[0]);

      // Randomised stream under random backpressure, checked against the reference model.
      mon_en      = 1'b1;
      base        = n_recv;
      n_sent      = 0;
      stream_done = 1'b0;
      fork
         begin
            for (int i = 0; i < 300; i++) begin
               if ($urandom_range(0, 3) == 0) @(negedge clk);
               drive(rand_op(), rand_op(), 3'($urandom_range(0, 7)), 6'(i));
            end
            stream_done = 1'b1;
         end
         begin
            while (!stream_done) begin
               bus.out_ready = ($urandom_range(0, 2) != 0);
               @(negedge clk);
            end
            bus.out_ready = 1'b1;
         end
      join
      w = 0;
      while (exp_q.size() != 0 && w < 200) begin
         @(negedge clk);
         w++;
      end
      check("rand_drain", 32'(exp_q.size()), 32'd0);
      check("rand_count", 32'(n_recv - base), 32'(n_sent));
      @(negedge clk);
      #1;
      check("idle_out_valid", 32'(bus.out_valid), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
